sprite_scan_gen: RTL and testbench

Scan-timing and sprite-coordinate generator that drives the pixel side of the sprite renderers. It produces 640x480@60 Hz VGA sync and display-enable, the current screen pixel (DrawX/DrawY), and sprite-relative coordinates (DistX/DistY) plus an in-sprite flag. Renderers form their ROM address from DistX/DistY and register RGB one cycle later, so this block also provides one-cycle-delayed sync outputs. Sprite position is loaded through a valid/ready handshake and takes effect only at frame start, so a sprite never tears mid-frame.

---
 rtl/sprite_scan_gen.sv | 183 ++++++++++++++++++
 tb/tb_sprite_scan_gen.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_scan_gen.sv
// sprite_scan_gen: VGA scan-timing generator with frame-synchronous sprite placement.
// The pixel counters advance on every clock. Each decoded output (sync, blank, in_sprite,
// DistX/DistY, frame_start, pos_ready) is registered from the next-state counters, so it
// lines up with DrawX/DrawY. Position requests are clamped and parked in a pending slot.
// They are promoted to the active slot only when the counters wrap to (0,0), which keeps a
// sprite from tearing part-way through a frame.
module sprite_scan_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int SPRITE_W  = 20,
  parameter int SPRITE_H  = 20
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  input  logic [9:0]  sprite_x,
  input  logic [9:0]  sprite_y,
  input  logic        pos_valid,
  output logic        pos_ready,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        blank,
  output logic        hs,
  output logic        vs,
  output logic        hs_d,
  output logic        vs_d,
  output logic        in_sprite,
  output logic [19:0] DistX,
  output logic [19:0] DistY,
  output logic        frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0]  H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0]  V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0]  HS_BEG = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0]  HS_END = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0]  VS_BEG = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0]  VS_END = 10'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [9:0]  SX_MAX = 10'(H_VISIBLE - SPRITE_W);
  localparam logic [9:0]  SY_MAX = 10'(V_VISIBLE - SPRITE_H);
  localparam logic [10:0] SP_W   = 11'(SPRITE_W);
  localparam logic [10:0] SP_H   = 11'(SPRITE_H);

  // Keeps the whole sprite box on screen.
  function automatic logic [9:0] clamp_pos(input logic [9:0] req, input logic [9:0] lim);
    if (req > lim) begin
      return lim;
    end else begin
      return req;
    end
  endfunction

  // run_r is low for the single cycle after reset release, so the first counted state is (0,0).
  logic        run_r;
  logic [9:0]  sx_r, sy_r;
  logic [9:0]  px_r, py_r;
  logic        pend_r;

  logic        x_last_s, y_last_s, wrap_s, fire_s, apply_s;
  logic [9:0]  next_x_s, next_y_s, next_sx_s, next_sy_s;
  logic        next_pend_s, next_blank_s, next_hs_s, next_vs_s, next_in_s, next_ready_s;
  logic [19:0] next_dx_s, next_dy_s;

  // Next-state counters, next active position and the decoded outputs for the next pixel.
  always_comb begin
    x_last_s = (DrawX == H_LAST);
    y_last_s = (DrawY == V_LAST);
    wrap_s   = run_r && x_last_s && y_last_s;
    fire_s   = pos_valid && pos_ready;
    apply_s  = wrap_s && pend_r;

    if (!run_r) begin
      next_x_s = 10'd0;
      next_y_s = 10'd0;
    end else if (x_last_s) begin
      next_x_s = 10'd0;
      if (y_last_s) begin
        next_y_s = 10'd0;
      end else begin
        next_y_s = DrawY + 10'd1;
      end
    end else begin
      next_x_s = DrawX + 10'd1;
      next_y_s = DrawY;
    end

    // The new position must already govern the first pixel of the new frame.
    if (apply_s) begin
      next_sx_s = px_r;
      next_sy_s = py_r;
    end else begin
      next_sx_s = sx_r;
      next_sy_s = sy_r;
    end

    // A transfer on the apply cycle refills the slot that is being emptied.
    if (fire_s) begin
      next_pend_s = 1'b1;
    end else if (apply_s) begin
      next_pend_s = 1'b0;
    end else begin
      next_pend_s = pend_r;
    end

    next_blank_s = (next_x_s < H_VIS) && (next_y_s < V_VIS);
    next_hs_s    = !((next_x_s >= HS_BEG) && (next_x_s < HS_END));
    next_vs_s    = !((next_y_s >= VS_BEG) && (next_y_s < VS_END));

    next_in_s = next_blank_s
             && (next_x_s >= next_sx_s) && ({1'b0, next_x_s} < ({1'b0, next_sx_s} + SP_W))
             && (next_y_s >= next_sy_s) && ({1'b0, next_y_s} < ({1'b0, next_sy_s} + SP_H));

    if (next_in_s) begin
      next_dx_s = {10'd0, next_x_s - next_sx_s};
      next_dy_s = {10'd0, next_y_s - next_sy_s};
    end else begin
      next_dx_s = 20'd0;
      next_dy_s = 20'd0;
    end

    // Ready while the slot is free, or on the last pixel where the slot drains.
    next_ready_s = !next_pend_s || ((next_x_s == H_LAST) && (next_y_s == V_LAST));
  end

  // State and registered outputs; reset discards any pending request.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      run_r       <= 1'b0;
      DrawX       <= 10'd0;
      DrawY       <= 10'd0;
      sx_r        <= 10'd0;
      sy_r        <= 10'd0;
      px_r        <= 10'd0;
      py_r        <= 10'd0;
      pend_r      <= 1'b0;
      pos_ready   <= 1'b1;
      blank       <= 1'b0;
      hs          <= 1'b1;
      vs          <= 1'b1;
      hs_d        <= 1'b1;
      vs_d        <= 1'b1;
      in_sprite   <= 1'b0;
      DistX       <= 20'd0;
      DistY       <= 20'd0;
      frame_start <= 1'b0;
    end else begin
      run_r       <= 1'b1;
      DrawX       <= next_x_s;
      DrawY       <= next_y_s;
      sx_r        <= next_sx_s;
      sy_r        <= next_sy_s;
      pend_r      <= next_pend_s;
      if (fire_s) begin
        px_r <= clamp_pos(sprite_x, SX_MAX);
        py_r <= clamp_pos(sprite_y, SY_MAX);
      end else begin
        px_r <= px_r;
        py_r <= py_r;
      end
      pos_ready   <= next_ready_s;
      blank       <= next_blank_s;
      hs          <= next_hs_s;
      vs          <= next_vs_s;
      hs_d        <= hs;
      vs_d        <= vs;
      in_sprite   <= next_in_s;
      DistX       <= next_dx_s;
      DistY       <= next_dy_s;
      frame_start <= wrap_s;
    end
  end

endmodule

// File: tb/tb_sprite_scan_gen.sv
// Directed bench for sprite_scan_gen. A full-size instance checks line timing at the
// standard 640x480 numbers. A reduced-geometry instance (176x86 total, 160x80 visible)
// exercises frame-level behaviour (vsync, frame_start, sprite apply and stall, clamping,
// reset mid-frame) in a manageable number of cycles.
module tb_sprite_scan_gen;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  sprite_x, sprite_y;
  logic        pos_valid;

  logic        s_ready, s_blank, s_hs, s_vs, s_hs_d, s_vs_d, s_in, s_fs;
  logic [9:0]  s_x, s_y;
  logic [19:0] s_dx, s_dy;

  logic        f_ready, f_blank, f_hs, f_vs, f_hs_d, f_vs_d, f_in, f_fs;
  logic [9:0]  f_x, f_y;
  logic [19:0] f_dx, f_dy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int fs_cnt = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb_q[$];

  sprite_scan_gen #(
    .H_VISIBLE(160), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_VISIBLE(80),  .V_FP(2), .V_SYNC(2), .V_BP(2),
    .SPRITE_W(20),   .SPRITE_H(20)
  ) dut (
    .vga_clk(clk), .reset_n(reset_n), .sprite_x(sprite_x), .sprite_y(sprite_y),
    .pos_valid(pos_valid), .pos_ready(s_ready), .DrawX(s_x), .DrawY(s_y),
    .blank(s_blank), .hs(s_hs), .vs(s_vs), .hs_d(s_hs_d), .vs_d(s_vs_d),
    .in_sprite(s_in), .DistX(s_dx), .DistY(s_dy), .frame_start(s_fs)
  );

  sprite_scan_gen dut_full (
    .vga_clk(clk), .reset_n(reset_n), .sprite_x(10'd0), .sprite_y(10'd0),
    .pos_valid(1'b0), .pos_ready(f_ready), .DrawX(f_x), .DrawY(f_y),
    .blank(f_blank), .hs(f_hs), .vs(f_vs), .hs_d(f_hs_d), .vs_d(f_vs_d),
    .in_sprite(f_in), .DistX(f_dx), .DistY(f_dy), .frame_start(f_fs)
  );

  always #5 clk = ~clk;

  // Count frame_start pulses of the reduced instance, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset_n && s_fs) fs_cnt <= fs_cnt + 1;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic to_cycle(input int c);
    while (cyc < c) step(1);
  endtask

  task automatic expect_v(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed=%0d expected=none", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: observed=%0d expected=%0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic goto_px(input int x, input int y);
    int n = 0;
    while (!((int'(s_x) == x) && (int'(s_y) == y)) && (n < 20000)) begin
      step(1);
      n++;
    end
    if (n >= 20000) begin
      checks++;
      errors++;
      $error("FAIL goto_timeout: observed=(%0d,%0d) expected=(%0d,%0d)", s_x, s_y, x, y);
    end
  endtask

  task automatic px_check(input string tg, input int x, input int y,
                          input logic [31:0] e_in, input logic [31:0] e_dx, input logic [31:0] e_dy);
    expect_v({tg, "_in"}, e_in);
    expect_v({tg, "_dx"}, e_dx);
    expect_v({tg, "_dy"}, e_dy);
    goto_px(x, y);
    check(32'(s_in));
    check(32'(s_dx));
    check(32'(s_dy));
  endtask

  task automatic send(input logic [9:0] x, input logic [9:0] y,
                      output logic [9:0] ax, output logic [9:0] ay);
    int   n    = 0;
    logic done = 1'b0;
    ax = 10'd0;
    ay = 10'd0;
    sprite_x  = x;
    sprite_y  = y;
    pos_valid = 1'b1;
    while (!done && (n < 20000)) begin
      if (s_ready) begin
        ax   = s_x;
        ay   = s_y;
        done = 1'b1;
      end
      step(1);
      n++;
    end
    pos_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $error("FAIL send_timeout: observed=stalled expected=accepted");
    end
  endtask

  logic [9:0] acc_x, acc_y;

  initial begin
    reset_n   = 1'b0;
    pos_valid = 1'b0;
    sprite_x  = 10'd0;
    sprite_y  = 10'd0;
    step(3);

    // Reset values.
    expect_v("rst_x", 32'd0);      expect_v("rst_y", 32'd0);
    expect_v("rst_blank", 32'd0);  expect_v("rst_hs", 32'd1);
    expect_v("rst_vs", 32'd1);     expect_v("rst_hs_d", 32'd1);
    expect_v("rst_vs_d", 32'd1);   expect_v("rst_in", 32'd0);
    expect_v("rst_dx", 32'd0);     expect_v("rst_dy", 32'd0);
    expect_v("rst_fs", 32'd0);     expect_v("rst_ready", 32'd1);
    expect_v("rst_full_blank", 32'd0);
    check(32'(s_x));    check(32'(s_y));    check(32'(s_blank)); check(32'(s_hs));
    check(32'(s_vs));   check(32'(s_hs_d)); check(32'(s_vs_d));  check(32'(s_in));
    check(32'(s_dx));   check(32'(s_dy));   check(32'(s_fs));    check(32'(s_ready));
    check(32'(f_blank));

    // Release: the first counted state is (0,0), visible.
    reset_n = 1'b1;
    cyc = -1;
    expect_v("c0_x", 32'd0); expect_v("c0_y", 32'd0);
    expect_v("c0_blank", 32'd1); expect_v("c0_fs", 32'd0); expect_v("c0_full_blank", 32'd1);
    step(1);
    check(32'(s_x)); check(32'(s_y)); check(32'(s_blank)); check(32'(s_fs)); check(32'(f_blank));

    // Request (100,50) early in frame 0; ready drops the next cycle.
    to_cycle(100);
    send(10'd100, 10'd50, acc_x, acc_y);
    expect_v("req1_ready_drop", 32'd0);
    check(32'(s_ready));

    // Sprite still at (0,0) for the rest of frame 0.
    px_check("f0_old_5_3", 5, 3, 32'd1, 32'd5, 32'd3);

    // Full-size line timing.
    expect_v("full_639_x", 32'd639); expect_v("full_639_blank", 32'd1);
    to_cycle(639); check(32'(f_x)); check(32'(f_blank));
    expect_v("full_640_blank", 32'd0);
    to_cycle(640); check(32'(f_blank));
    expect_v("full_655_hs", 32'd1);
    to_cycle(655); check(32'(f_hs));
    expect_v("full_656_hs", 32'd0); expect_v("full_656_hs_d", 32'd1);
    to_cycle(656); check(32'(f_hs)); check(32'(f_hs_d));
    expect_v("full_657_hs_d", 32'd0);
    to_cycle(657); check(32'(f_hs_d));
    expect_v("full_751_hs", 32'd0);
    to_cycle(751); check(32'(f_hs));
    expect_v("full_752_hs", 32'd1); expect_v("full_752_hs_d", 32'd0);
    to_cycle(752); check(32'(f_hs)); check(32'(f_hs_d));
    expect_v("full_753_hs_d", 32'd1);
    to_cycle(753); check(32'(f_hs_d));
    expect_v("full_800_x", 32'd0); expect_v("full_800_y", 32'd1); expect_v("full_800_vs", 32'd1);
    to_cycle(800); check(32'(f_x)); check(32'(f_y)); check(32'(f_vs));
    expect_v("full_1456_hs", 32'd0);
    to_cycle(1456); check(32'(f_hs));

    px_check("f0_105_53", 105, 53, 32'd0, 32'd0, 32'd0);

    // Vertical sync on lines 82-83 of the reduced frame.
    expect_v("vs_81", 32'd1);   goto_px(0, 81);   check(32'(s_vs));
    expect_v("vs_82", 32'd0);   expect_v("vs_d_82", 32'd1);
    goto_px(0, 82);   check(32'(s_vs)); check(32'(s_vs_d));
    expect_v("vs_d_1_82", 32'd0); goto_px(1, 82); check(32'(s_vs_d));
    expect_v("vs_83", 32'd0);   goto_px(175, 83); check(32'(s_vs));
    expect_v("vs_84", 32'd1);   goto_px(0, 84);   check(32'(s_vs));

    // Last pixel of frame 0: ready reopens for the apply cycle; no frame_start yet.
    expect_v("f0_last_fs", 32'd0); expect_v("f0_last_ready", 32'd1); expect_v("f0_fs_cnt", 32'd0);
    goto_px(175, 85); check(32'(s_fs)); check(32'(s_ready)); check(32'(fs_cnt));
    expect_v("f1_start_fs", 32'd1); expect_v("f1_start_ready", 32'd1);
    step(1); check(32'(s_fs)); check(32'(s_ready));
    expect_v("f1_fs_low", 32'd0); expect_v("f1_fs_cnt", 32'd1);
    step(1); check(32'(s_fs)); check(32'(fs_cnt));

    // Frame 1: sprite at (100,50).
    px_check("f1_99_50", 99, 50, 32'd0, 32'd0, 32'd0);
    px_check("f1_100_50", 100, 50, 32'd1, 32'd0, 32'd0);
    px_check("f1_105_53", 105, 53, 32'd1, 32'd5, 32'd3);
    px_check("f1_119_53", 119, 53, 32'd1, 32'd19, 32'd3);
    px_check("f1_120_53", 120, 53, 32'd0, 32'd0, 32'd0);

    // Request (30,40) mid-frame, then a second request that must stall until the wrap.
    goto_px(0, 60);
    send(10'd30, 10'd40, acc_x, acc_y);
    expect_v("req2_ready_drop", 32'd0);
    check(32'(s_ready));
    px_check("f1_hold_105_65", 105, 65, 32'd1, 32'd5, 32'd15);
    send(10'd630, 10'd470, acc_x, acc_y);
    expect_v("req3_acc_x", 32'd175); expect_v("req3_acc_y", 32'd85);
    check(32'(acc_x)); check(32'(acc_y));
    expect_v("f2_start_fs", 32'd1); expect_v("f2_start_ready", 32'd0);
    check(32'(s_fs)); check(32'(s_ready));

    // Frame 2: sprite at (30,40).
    px_check("f2_35_43", 35, 43, 32'd1, 32'd5, 32'd3);
    px_check("f2_105_53", 105, 53, 32'd0, 32'd0, 32'd0);
    goto_px(175, 85);
    expect_v("f3_start_ready", 32'd1);
    step(1); check(32'(s_ready));

    // Frame 3: clamped to (140,60).
    px_check("f3_139_60", 139, 60, 32'd0, 32'd0, 32'd0);
    px_check("f3_140_60", 140, 60, 32'd1, 32'd0, 32'd0);
    px_check("f3_159_79", 159, 79, 32'd1, 32'd19, 32'd19);

    // Leave a request pending, then reset mid-frame inside hsync and vsync.
    goto_px(165, 79);
    send(10'd10, 10'd10, acc_x, acc_y);
    expect_v("pre_rst_hs", 32'd0); expect_v("pre_rst_vs", 32'd0); expect_v("pre_rst_ready", 32'd0);
    goto_px(170, 82); check(32'(s_hs)); check(32'(s_vs)); check(32'(s_ready));
    reset_n = 1'b0;
    #2;
    expect_v("arst_x", 32'd0);  expect_v("arst_y", 32'd0);   expect_v("arst_hs", 32'd1);
    expect_v("arst_vs", 32'd1); expect_v("arst_vs_d", 32'd1); expect_v("arst_ready", 32'd1);
    check(32'(s_x));  check(32'(s_y));    check(32'(s_hs));
    check(32'(s_vs)); check(32'(s_vs_d)); check(32'(s_ready));
    step(2);
    reset_n = 1'b1;
    cyc = -1;
    step(1);

    // After release the pending (10,10) is gone: sprite stays at (0,0) across the wrap.
    px_check("post_f0_5_3", 5, 3, 32'd1, 32'd5, 32'd3);
    goto_px(175, 85);
    expect_v("post_f1_fs", 32'd1); expect_v("post_f1_ready", 32'd1);
    step(1); check(32'(s_fs)); check(32'(s_ready));
    px_check("post_f1_5_3", 5, 3, 32'd1, 32'd5, 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
